machine_io_harness: RTL

Synthesizable stimulus/monitor harness for the accumulator processor's `final_machine`, parametrised in data width, queue depth and timeout. It holds a queue of values to drive onto the processor's `Inputio` port. It checks every `Output`-strobed `Outputio` value against a queue of expected results and counts cycles, mismatches and `Overflow` pulses. It ends in a PASS/FAIL/TIMEOUT verdict. It sits between the processor and either a bench or an FPGA debug front end.

---
 rtl/machine_io_harness_if.sv | 38 +++
 rtl/machine_io_harness.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/machine_io_harness_if.sv
// Harness-side bundle: load ports, processor handshake and run status.
// The harness is the slave; the bench or debug front end driving it is the master.
interface machine_io_harness_if #(
  parameter int DATA_W = 16,
  parameter int CYC_W  = 32
);
  logic              Start;
  logic              stim_wr;
  logic [DATA_W-1:0] stim_data;
  logic              exp_wr;
  logic [DATA_W-1:0] exp_data;
  logic              InputTaken;
  logic [DATA_W-1:0] Outputio;
  logic              Output;
  logic              Overflow;
  logic [DATA_W-1:0] Inputio;
  logic [2:0]        state;
  logic [CYC_W-1:0]  cycle_count;
  logic [7:0]        pass_count;
  logic [7:0]        fail_count;
  logic [7:0]        ovf_count;
  logic [DATA_W-1:0] first_bad;
  logic              load_err;

  modport slave (
    input  Start, stim_wr, stim_data, exp_wr, exp_data,
    input  InputTaken, Outputio, Output, Overflow,
    output Inputio, state, cycle_count, pass_count, fail_count,
    output ovf_count, first_bad, load_err
  );

  modport master (
    output Start, stim_wr, stim_data, exp_wr, exp_data,
    output InputTaken, Outputio, Output, Overflow,
    input  Inputio, state, cycle_count, pass_count, fail_count,
    input  ovf_count, first_bad, load_err
  );
endinterface

// File: rtl/machine_io_harness.sv
// Stimulus/compare harness for final_machine: stimulus and expected queues, edge-detected compares, verdict FSM.
// Status is registered (Output rise at edge k lands at edge k); Inputio is combinational; no backpressure, dropped pushes flag load_err.
module machine_io_harness #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096,
  parameter int CYC_W   = 32
) (
  input logic              CLK,
  input logic              Reset,
  machine_io_harness_if.slave io
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] stim_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem  [DEPTH];
  logic [AW-1:0]     stim_wp_q, stim_wp_d, stim_rp_q, stim_rp_d;
  logic [AW-1:0]     exp_wp_q, exp_wp_d, exp_rp_q, exp_rp_d;
  logic [CW-1:0]     stim_cnt_q, stim_cnt_d, exp_cnt_q, exp_cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [7:0]        pass_q, pass_d, fail_q, fail_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] first_bad_q, first_bad_d;
  logic              load_err_q, load_err_d;
  logic              output_q, overflow_q;
  logic              stim_push, exp_push;
  logic              out_edge, ovf_edge;

  assign out_edge = io.Output & ~output_q;
  assign ovf_edge = io.Overflow & ~overflow_q;

  always_comb begin
    state_d     = state_q;
    stim_wp_d   = stim_wp_q;
    stim_rp_d   = stim_rp_q;
    stim_cnt_d  = stim_cnt_q;
    exp_wp_d    = exp_wp_q;
    exp_rp_d    = exp_rp_q;
    exp_cnt_d   = exp_cnt_q;
    tmr_d       = tmr_q;
    cyc_d       = cyc_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ovf_d       = ovf_q;
    first_bad_d = first_bad_q;
    load_err_d  = load_err_q;
    stim_push   = 1'b0;
    exp_push    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (io.stim_wr) begin
          if (stim_cnt_q == FULL) begin
            load_err_d = 1'b1;
          end else begin
            stim_push  = 1'b1;
            stim_wp_d  = stim_wp_q + 1'b1;
            stim_cnt_d = stim_cnt_q + 1'b1;
          end
        end
        if (io.exp_wr) begin
          if (exp_cnt_q == FULL) begin
            load_err_d = 1'b1;
          end else begin
            exp_push  = 1'b1;
            exp_wp_d  = exp_wp_q + 1'b1;
            exp_cnt_d = exp_cnt_q + 1'b1;
          end
        end
        if (io.Start) begin
          tmr_d   = '0;
          state_d = (exp_cnt_q == '0) ? S_PASS : S_RUN;
        end
      end

      S_RUN: begin
        if (io.stim_wr || io.exp_wr) load_err_d = 1'b1;
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (io.InputTaken && (stim_cnt_q != '0)) begin
          stim_rp_d  = stim_rp_q + 1'b1;
          stim_cnt_d = stim_cnt_q - 1'b1;
        end
        if (ovf_edge && (ovf_q != 8'hFF)) ovf_d = ovf_q + 1'b1;

        // A compare edge restarts the timeout window, so it wins over an expiring timer.
        if (out_edge) begin
          exp_rp_d  = exp_rp_q + 1'b1;
          exp_cnt_d = exp_cnt_q - 1'b1;
          tmr_d     = '0;
          if (io.Outputio == exp_mem[exp_rp_q]) begin
            if (pass_q != 8'hFF) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != 8'hFF) fail_d = fail_q + 1'b1;
            if (fail_q == 8'd0) first_bad_d = io.Outputio;
          end
          if (exp_cnt_q == CW'(1)) state_d = (fail_d == 8'd0) ? S_PASS : S_FAIL;
        end else if (tmr_q == TLAST) begin
          state_d = S_TMO;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      stim_wp_q   <= '0;
      stim_rp_q   <= '0;
      stim_cnt_q  <= '0;
      exp_wp_q    <= '0;
      exp_rp_q    <= '0;
      exp_cnt_q   <= '0;
      tmr_q       <= '0;
      cyc_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      ovf_q       <= '0;
      first_bad_q <= '0;
      load_err_q  <= 1'b0;
      output_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stim_wp_q   <= stim_wp_d;
      stim_rp_q   <= stim_rp_d;
      stim_cnt_q  <= stim_cnt_d;
      exp_wp_q    <= exp_wp_d;
      exp_rp_q    <= exp_rp_d;
      exp_cnt_q   <= exp_cnt_d;
      tmr_q       <= tmr_d;
      cyc_q       <= cyc_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ovf_q       <= ovf_d;
      first_bad_q <= first_bad_d;
      load_err_q  <= load_err_d;
      output_q    <= io.Output;
      overflow_q  <= io.Overflow;
    end
  end

  // Storage needs no reset: occupancy counts alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (stim_push) stim_mem[stim_wp_q] <= io.stim_data;
    if (exp_push)  exp_mem[exp_wp_q]   <= io.exp_data;
  end

  assign io.Inputio     = ((state_q == S_RUN) && (stim_cnt_q != '0)) ? stim_mem[stim_rp_q] : '0;
  assign io.state       = state_q;
  assign io.cycle_count = cyc_q;
  assign io.pass_count  = pass_q;
  assign io.fail_count  = fail_q;
  assign io.ovf_count   = ovf_q;
  assign io.first_bad   = first_bad_q;
  assign io.load_err    = load_err_q;
endmodule
